// File: rtl/z_writeback.sv
// z_writeback: ALU result write-back stage.
// Buffers 64-bit ALU results in a small FIFO and streams them onto the 32-bit
// bus as one beat (narrow ops) or two beats low-then-high (mul/div, ops 10/11).
// Also holds the architectural Z_LO/Z_HI registers of the last retired result.
// Optional feature macro: Z_WRITEBACK_FLAGS_EN adds z_zero/z_neg retire flags.
module z_writeback #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_result,
    input  logic [4:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_hi,
    output logic        out_last,
    output logic [31:0] z_lo,
    output logic [31:0] z_hi
`ifdef Z_WRITEBACK_FLAGS_EN
    ,
    output logic        z_zero,
    output logic        z_neg
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [64:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_zLo;
    logic [31:0]        r_zHi;
    logic [64:0]        w_head;
    logic               w_headWide;
    logic               w_inWide;
    logic               w_push;
    logic               w_pop;

    // Each entry carries a wide flag so the output FSM knows whether a high beat follows.
    assign w_inWide   = (in_op == 5'd10) || (in_op == 5'd11);
    assign w_head     = r_mem[r_rdPtr];
    assign w_headWide = w_head[64];

    // Ready comes from the registered count only, so a pop never enables a same-cycle push when full.
    assign in_ready = (r_count < CNT_W'(DEPTH));
    assign w_push   = in_valid && in_ready;

    assign z_lo = r_zLo;
    assign z_hi = r_zHi;

    // Entry storage; not reset because the output mux ignores it while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {w_inWide, in_result};
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Output FSM state register; reset drops any partially sent entry.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Beat selection and sequencing; all outputs derive from the state and FIFO head only.
    always_comb begin
        w_nextState = r_state;
        out_valid   = 1'b0;
        out_data    = 32'h0;
        out_hi      = 1'b0;
        out_last    = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_count != '0) || w_push) begin
                    w_nextState = ST_LO;
                end
            end
            ST_LO: begin
                out_valid = 1'b1;
                out_data  = w_head[31:0];
                out_last  = !w_headWide;
                if (out_ready) begin
                    if (w_headWide) begin
                        w_nextState = ST_HI;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
            end
            ST_HI: begin
                out_valid = 1'b1;
                out_data  = w_head[63:32];
                out_hi    = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    w_pop = 1'b1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (w_pop) begin
            w_nextState = ((r_count > CNT_W'(1)) || w_push) ? ST_LO : ST_IDLE;
        end
    end

    // Architectural Z registers load the full 64-bit head when its final beat is accepted.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_zLo <= 32'h0;
            r_zHi <= 32'h0;
        end else if (w_pop) begin
            r_zLo <= w_head[31:0];
            r_zHi <= w_head[63:32];
        end
    end

`ifdef Z_WRITEBACK_FLAGS_EN
    logic r_zZero;
    logic r_zNeg;

    assign z_zero = r_zZero;
    assign z_neg  = r_zNeg;

    // Zero/negative flags of the retired value, captured alongside Z_LO/Z_HI.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_zZero <= 1'b0;
            r_zNeg  <= 1'b0;
        end else if (w_pop) begin
            r_zZero <= (w_head[63:0] == 64'h0);
            r_zNeg  <= w_head[63];
        end
    end
`endif

endmodule

// File: tb/tb_z_writeback.sv
// Testbench for z_writeback: directed vector table, hand-written reset and
// wrap sequences, and randomized traffic checked against a queue-based model.
module tb_z_writeback;

    localparam int DEPTH = 2;

    logic        clock;
    logic        clear;
    logic        inValid;
    logic        inReady;
    logic [63:0] inResult;
    logic [4:0]  inOp;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic        outHi;
    logic        outLast;
    logic [31:0] zLo;
    logic [31:0] zHi;
`ifdef Z_WRITEBACK_FLAGS_EN
    logic        zZero;
    logic        zNeg;
`endif

    int nChecks = 0;
    int nPass   = 0;

    z_writeback #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_result (inResult),
        .in_op     (inOp),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_hi    (outHi),
        .out_last  (outLast),
        .z_lo      (zLo),
        .z_hi      (zHi)
`ifdef Z_WRITEBACK_FLAGS_EN
        ,
        .z_zero    (zZero),
        .z_neg     (zNeg)
`endif
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Directed vector record: inputs applied before an edge, outputs expected after it
    typedef struct {
        logic        inV;
        logic [63:0] res;
        logic [4:0]  op;
        logic        rdy;
        logic        eValid;
        logic [31:0] eData;
        logic        eHi;
        logic        eLast;
        logic        eInReady;
        logic [31:0] eZLo;
        logic [31:0] eZHi;
    } vec_t;

    vec_t vecs[12];

    // Reference model: FIFO of {wide, result} entries plus which beat of the head is showing
    logic [64:0] mQ[$];
    int          mBeat;
    logic [31:0] mZLo;
    logic [31:0] mZHi;
    logic        mZero;
    logic        mNeg;

    // Single comparison with pass/fail bookkeeping
    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every bus-visible output against expected values
    task automatic checkOutput(input string tag, input logic v, input logic [31:0] d,
                               input logic h, input logic l, input logic r,
                               input logic [31:0] zl, input logic [31:0] zh);
        checkVal({tag, ".out_valid"}, 64'(outValid), 64'(v));
        checkVal({tag, ".out_data"},  64'(outData),  64'(d));
        checkVal({tag, ".out_hi"},    64'(outHi),    64'(h));
        checkVal({tag, ".out_last"},  64'(outLast),  64'(l));
        checkVal({tag, ".in_ready"},  64'(inReady),  64'(r));
        checkVal({tag, ".z_lo"},      64'(zLo),      64'(zl));
        checkVal({tag, ".z_hi"},      64'(zHi),      64'(zh));
    endtask

    // Drive all DUT inputs
    task automatic applyStimulus(input logic v, input logic [63:0] res, input logic [4:0] op,
                                 input logic rdy);
        inValid  = v;
        inResult = res;
        inOp     = op;
        outReady = rdy;
    endtask

    task automatic modelReset();
        mQ.delete();
        mBeat = 0;
        mZLo  = 32'h0;
        mZHi  = 32'h0;
        mZero = 1'b0;
        mNeg  = 1'b0;
    endtask

    // What the model says the outputs should be right now
    task automatic modelOutputs(output logic v, output logic [31:0] d, output logic h,
                                output logic l, output logic r);
        logic [64:0] e;
        v = (mQ.size() > 0);
        r = (mQ.size() < DEPTH);
        d = 32'h0;
        h = 1'b0;
        l = 1'b0;
        if (v) begin
            e = mQ[0];
            d = (mBeat == 1) ? e[63:32] : e[31:0];
            h = (mBeat == 1);
            l = !e[64] || (mBeat == 1);
        end
    endtask

    // Compare DUT against the model
    task automatic checkModel(input string tag);
        logic v, h, l, r;
        logic [31:0] d;
        modelOutputs(v, d, h, l, r);
        checkOutput(tag, v, d, h, l, r, mZLo, mZHi);
`ifdef Z_WRITEBACK_FLAGS_EN
        checkVal({tag, ".z_zero"}, 64'(zZero), 64'(mZero));
        checkVal({tag, ".z_neg"},  64'(zNeg),  64'(mNeg));
`endif
    endtask

    // Advance the model over one edge using the currently driven inputs, then clock the DUT and compare
    task automatic stepModel(input string tag, output logic pushed, output logic accepted);
        logic v, h, l, r;
        logic [31:0] d;
        logic [64:0] e;
        modelOutputs(v, d, h, l, r);
        accepted = v && outReady;
        pushed   = inValid && r;
        if (accepted) begin
            e = mQ[0];
            if (l) begin
                mZLo  = e[31:0];
                mZHi  = e[63:32];
                mZero = (e[63:0] == 64'h0);
                mNeg  = e[63];
                void'(mQ.pop_front());
                mBeat = 0;
            end else begin
                mBeat = 1;
            end
        end
        if (pushed) begin
            mQ.push_back({(inOp == 5'd10) || (inOp == 5'd11), inResult});
        end
        @(posedge clock);
        #1;
        checkModel(tag);
    endtask

    // Full synchronous-safe reset of DUT and model, released away from the clock edge
    task automatic doReset();
        applyStimulus(1'b0, 64'h0, 5'd0, 1'b0);
        clear = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
    endtask

    initial begin
        logic pushed, accepted;
        int   entries, beats, cyc;

        // Hand-derived vectors: narrow op, wide op, backpressure/full, drain in order
        vecs[0]  = '{1'b1, 64'hFFFF_FFFF_8000_0001, 5'd2,  1'b1, 1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b1, 32'h0,          32'h0};
        vecs[1]  = '{1'b0, 64'h0,                   5'd0,  1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 64'h0000_0002_0000_0003, 5'd10, 1'b1, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF};
        vecs[3]  = '{1'b0, 64'h0,                   5'd0,  1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF};
        vecs[4]  = '{1'b0, 64'h0,                   5'd0,  1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0002};
        vecs[5]  = '{1'b1, 64'h1111_1111_AAAA_AAAA, 5'd2,  1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h0000_0002};
        vecs[6]  = '{1'b1, 64'h2222_2222_BBBB_BBBB, 5'd11, 1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0002};
        vecs[7]  = '{1'b1, 64'h3333_3333_CCCC_CCCC, 5'd3,  1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0002};
        vecs[8]  = '{1'b1, 64'h3333_3333_CCCC_CCCC, 5'd3,  1'b1, 1'b1, 32'hBBBB_BBBB, 1'b0, 1'b0, 1'b1, 32'hAAAA_AAAA, 32'h1111_1111};
        vecs[9]  = '{1'b1, 64'h3333_3333_CCCC_CCCC, 5'd3,  1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'h1111_1111};
        vecs[10] = '{1'b0, 64'h0,                   5'd0,  1'b1, 1'b1, 32'hCCCC_CCCC, 1'b0, 1'b1, 1'b1, 32'hBBBB_BBBB, 32'h2222_2222};
        vecs[11] = '{1'b0, 64'h0,                   5'd0,  1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'hCCCC_CCCC, 32'h3333_3333};

        // Reset values
        clear = 1'b0;
        applyStimulus(1'b0, 64'h0, 5'd0, 1'b0);
        modelReset();
        @(posedge clock);
        #1;
        checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        clear = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].inV, vecs[i].res, vecs[i].op, vecs[i].rdy);
            @(posedge clock);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eData, vecs[i].eHi,
                        vecs[i].eLast, vecs[i].eInReady, vecs[i].eZLo, vecs[i].eZHi);
        end

        // Reset asserted during the HI beat of a wide entry
        applyStimulus(1'b1, 64'h0000_0005_0000_0007, 5'd10, 1'b1);
        @(posedge clock);
        #1;
        checkOutput("midrst.lo", 1'b1, 32'h7, 1'b0, 1'b0, 1'b1, 32'hCCCC_CCCC, 32'h3333_3333);
        applyStimulus(1'b0, 64'h0, 5'd0, 1'b1);
        @(posedge clock);
        #1;
        checkOutput("midrst.hi", 1'b1, 32'h5, 1'b1, 1'b1, 1'b1, 32'hCCCC_CCCC, 32'h3333_3333);
        #2;
        clear = 1'b0;
        #1;
        checkOutput("midrst.async", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(posedge clock);
        #1;
        clear = 1'b1;
        applyStimulus(1'b1, 64'hFFFF_FFFF_8000_0001, 5'd2, 1'b1);
        @(posedge clock);
        #1;
        checkOutput("midrst.push", 1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 5'd0, 1'b1);
        @(posedge clock);
        #1;
        checkOutput("midrst.retire", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF);

        // Streaming with pointer wrap: 6 alternating narrow/wide entries, out_ready held high
        doReset();
        checkModel("wrap.start");
        entries = 0;
        beats   = 0;
        cyc     = 0;
        while (((entries < 6) || (mQ.size() > 0)) && (cyc < 40)) begin
            applyStimulus(entries < 6,
                          {32'h1000_0000 + 32'(entries), 32'h2000_0000 + 32'(entries)},
                          (entries % 2 == 1) ? 5'd10 : 5'd4, 1'b1);
            stepModel("wrap", pushed, accepted);
            if (pushed) entries++;
            if (accepted) beats++;
            cyc++;
        end
        checkVal("wrap.beats", 64'(beats), 64'd9);
        checkVal("wrap.entries", 64'(entries), 64'd6);

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          {$urandom, $urandom},
                          ($urandom_range(0, 2) == 0) ? 5'(10 + $urandom_range(0, 1))
                                                      : 5'($urandom_range(0, 9)),
                          $urandom_range(0, 3) != 0);
            stepModel("rand", pushed, accepted);
        end

`ifdef Z_WRITEBACK_FLAGS_EN
        // Flags on retire of zero and negative values
        doReset();
        applyStimulus(1'b1, 64'h0, 5'd1, 1'b1);
        stepModel("flag0.push", pushed, accepted);
        applyStimulus(1'b0, 64'h0, 5'd0, 1'b1);
        stepModel("flag0.retire", pushed, accepted);
        checkVal("flag0.z_zero", 64'(zZero), 64'd1);
        checkVal("flag0.z_neg",  64'(zNeg),  64'd0);
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 5'd1, 1'b1);
        stepModel("flagn.push", pushed, accepted);
        applyStimulus(1'b0, 64'h0, 5'd0, 1'b1);
        stepModel("flagn.retire", pushed, accepted);
        checkVal("flagn.z_zero", 64'(zZero), 64'd0);
        checkVal("flagn.z_neg",  64'(zNeg),  64'd1);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
